mealy_1001: RTL and testbench



---
 rtl/mealy_1001_pkg.sv | 25 ++
 rtl/mealy_1001.sv | 55 +++++
 tb/tb_mealy_1001.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mealy_1001_pkg.sv
// Shared types and constants for the 1-0-0-1 serial pattern detector.
//   state_t      : matched-prefix state, 2-bit binary encoding
//   PATTERN      : the detected bit pattern, first bit in the MSB
//   expected_bit : the next pattern bit that extends the current prefix
package mealy_1001_pkg;

    localparam int unsigned PATTERN_W = 4;
    localparam logic [PATTERN_W-1:0] PATTERN = 4'b1001;

    typedef enum logic [1:0] {
        S0 = 2'b00,  // nothing matched
        S1 = 2'b01,  // "1" matched
        S2 = 2'b10,  // "10" matched
        S3 = 2'b11   // "100" matched
    } state_t;

    // Each state's value equals the matched prefix length, so the bit it
    // waits for is the pattern bit just below the already matched MSBs.
    function automatic logic expected_bit(input state_t s);
        logic [1:0] idx;
        idx = 2'd3 - 2'(s);
        return PATTERN[idx];
    endfunction

endpackage

// File: rtl/mealy_1001.sv
// Mealy detector for the serial pattern 1-0-0-1 with a registered pulse.
// Ports:
//   reset_n : synchronous active-low reset (state -> S0, y -> 0)
//   clk     : clock, all updates on the rising edge
//   xin     : serial input bit, one per clock
//   y       : one-cycle detect pulse, set on the edge sampling the final '1'
// OVERLAP = 1 reuses the final '1' as the first bit of the next pattern.
module mealy_1001
    import mealy_1001_pkg::*;
#(
    parameter bit OVERLAP = 1'b0
) (
    input  logic reset_n,
    input  logic clk,
    input  logic xin,
    output logic y
);

    state_t state;
    state_t state_next;
    logic   detect_c;

    // State and detect registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S0;
            y     <= 1'b0;
        end else begin
            state <= state_next;
            y     <= detect_c;
        end
    end

    // Next state and detect. On a mismatch the only reusable prefix for
    // 1001 is a lone '1', so fall back to S1 on xin=1 and S0 on xin=0.
    always_comb begin
        state_next = state;
        detect_c   = 1'b0;
        if (xin == expected_bit(state)) begin
            case (state)
                S0: state_next = S1;
                S1: state_next = S2;
                S2: state_next = S3;
                S3: begin
                    detect_c   = 1'b1;
                    state_next = OVERLAP ? S1 : S0;
                end
                default: state_next = S0;
            endcase
        end else begin
            state_next = xin ? S1 : S0;
        end
    end

endmodule

// File: tb/tb_mealy_1001.sv
// Directed self-checking bench for mealy_1001; one instance per OVERLAP value
// driven by the same serial stream.
module tb_mealy_1001;
    import mealy_1001_pkg::*;

    logic clk;
    logic reset_n;
    logic xin;
    logic y0;
    logic y1;

    int n_cmp  = 0;
    int n_fail = 0;

    mealy_1001 #(.OVERLAP(1'b0)) dut0 (
        .reset_n (reset_n),
        .clk     (clk),
        .xin     (xin),
        .y       (y0)
    );

    mealy_1001 #(.OVERLAP(1'b1)) dut1 (
        .reset_n (reset_n),
        .clk     (clk),
        .xin     (xin),
        .y       (y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_y(input string tag, input logic e0, input logic e1);
        n_cmp++;
        assert (y0 === e0) else begin
            n_fail++;
            $error("FAIL %s ovl0 observed=%b expected=%b", tag, y0, e0);
        end
        n_cmp++;
        assert (y1 === e1) else begin
            n_fail++;
            $error("FAIL %s ovl1 observed=%b expected=%b", tag, y1, e1);
        end
    endtask

    // Present one bit, clock it in, sample just after the edge.
    task automatic send(input string tag, input logic b, input logic e0, input logic e1);
        xin = b;
        @(posedge clk);
        #1;
        check_y(tag, e0, e1);
    endtask

    // One reset edge with xin driven as given; y and state must clear.
    task automatic reset_edge(input string tag, input logic b);
        reset_n = 1'b0;
        xin     = b;
        @(posedge clk);
        #1;
        check_y(tag, 1'b0, 1'b0);
        n_cmp++;
        assert (dut0.state === S0 && dut1.state === S0) else begin
            n_fail++;
            $error("FAIL %s_state observed=%0d/%0d expected=%0d", tag,
                   dut0.state, dut1.state, S0);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        xin     = 1'b0;

        // Reset held two edges with xin toggling, then idle zeros.
        reset_edge("rst_a", 1'b1);
        reset_edge("rst_b", 1'b0);
        for (int i = 0; i < 8; i++) send("idle0", 1'b0, 1'b0, 1'b0);

        // Single detection: 1,0,0,1,0.
        reset_edge("rst_single", 1'b0);
        send("single_b1", 1'b1, 1'b0, 1'b0);
        send("single_b2", 1'b0, 1'b0, 1'b0);
        send("single_b3", 1'b0, 1'b0, 1'b0);
        send("single_b4", 1'b1, 1'b1, 1'b1);
        send("single_b5", 1'b0, 1'b0, 1'b0);

        // 1001001: one pulse without overlap, two with overlap.
        reset_edge("rst_ovl", 1'b0);
        send("ovl_b1", 1'b1, 1'b0, 1'b0);
        send("ovl_b2", 1'b0, 1'b0, 1'b0);
        send("ovl_b3", 1'b0, 1'b0, 1'b0);
        send("ovl_b4", 1'b1, 1'b1, 1'b1);
        send("ovl_b5", 1'b0, 1'b0, 1'b0);
        send("ovl_b6", 1'b0, 1'b0, 1'b0);
        send("ovl_b7", 1'b1, 1'b0, 1'b1);
        // Follow-on 1001: both instances sit in S1 and detect again.
        send("ovl_c1", 1'b1, 1'b0, 1'b0);
        send("ovl_c2", 1'b0, 1'b0, 1'b0);
        send("ovl_c3", 1'b0, 1'b0, 1'b0);
        send("ovl_c4", 1'b1, 1'b1, 1'b1);

        // Near miss 11001: S1 self-loop, pulse after bit 5.
        reset_edge("rst_nm1", 1'b0);
        send("nm1_b1", 1'b1, 1'b0, 1'b0);
        send("nm1_b2", 1'b1, 1'b0, 1'b0);
        send("nm1_b3", 1'b0, 1'b0, 1'b0);
        send("nm1_b4", 1'b0, 1'b0, 1'b0);
        send("nm1_b5", 1'b1, 1'b1, 1'b1);

        // Near miss 101001: S2 on '1' returns to S1, pulse after bit 6.
        reset_edge("rst_nm2", 1'b0);
        send("nm2_b1", 1'b1, 1'b0, 1'b0);
        send("nm2_b2", 1'b0, 1'b0, 1'b0);
        send("nm2_b3", 1'b1, 1'b0, 1'b0);
        send("nm2_b4", 1'b0, 1'b0, 1'b0);
        send("nm2_b5", 1'b0, 1'b0, 1'b0);
        send("nm2_b6", 1'b1, 1'b1, 1'b1);

        // Near miss 10001: no pulse.
        reset_edge("rst_nm3", 1'b0);
        send("nm3_b1", 1'b1, 1'b0, 1'b0);
        send("nm3_b2", 1'b0, 1'b0, 1'b0);
        send("nm3_b3", 1'b0, 1'b0, 1'b0);
        send("nm3_b4", 1'b0, 1'b0, 1'b0);
        send("nm3_b5", 1'b1, 1'b0, 1'b0);

        // Reset from S3 with xin=1 must win over the detect, then restart.
        reset_edge("rst_mid0", 1'b0);
        send("mid_b1", 1'b1, 1'b0, 1'b0);
        send("mid_b2", 1'b0, 1'b0, 1'b0);
        send("mid_b3", 1'b0, 1'b0, 1'b0);
        reset_edge("rst_mid", 1'b1);
        send("mid_r1", 1'b1, 1'b0, 1'b0);
        send("mid_r2", 1'b0, 1'b0, 1'b0);
        send("mid_r3", 1'b0, 1'b0, 1'b0);
        send("mid_r4", 1'b1, 1'b1, 1'b1);
        send("mid_r5", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
